bus_address_transmitter: RTL and testbench
==========================================

Name: bus_address_transmitter

Overview:
- Master-side transmitter that serialises a slave select and memory address onto the serial bus. It drives the same lines the slave-side address decoder samples: B_UTIL, A_ADD and B_BUS_OUT.
- It accepts a parallel request from the master core and performs the split-slave busy check before claiming the bus.
- It sends the slave-id bits (A_ADD high), waits for slave acknowledge, then shifts out the memory address.
- It reports completion, a timeout error or a split-retry back to the master core.

Parameters:
- SLAVE_W, 2: width of slave id field (00 = 2K slave, 01 = 4K non-split slave, 10 = 4K split slave).
- ADDR_W, 12: width of memory address field.
- SPLIT_ID, 2'b10: slave id of the split-capable slave.
- TIMEOUT, 8: maximum cycles spent in WAIT_RDY before abort.

Ports:
- CLK  in  1  bus clock, all logic on rising edge.
- RSTN  in  1  asynchronous active-low reset.
- M_REQ  in  1  transfer request from master core, sampled only in IDLE.
- M_SLAVE_ID  in  SLAVE_W  target slave id, captured with M_REQ.
- M_ADDR  in  ADDR_W  target memory address, captured with M_REQ.
- B_SBSY  in  1  split slave busy flag from bus.
- S_READY  in  1  slave acknowledge after id phase.
- B_UTIL  out  1  bus utilised; high for every cycle the transmitter owns the line.
- A_ADD  out  1  slave-id phase flag.
- B_BUS_OUT  out  1  serial data bit.
- M_BUSY  out  1  high from accept until return to IDLE.
- M_DONE  out  1  one-cycle completion pulse.
- M_ERR  out  1  one-cycle timeout pulse.
- M_RETRY  out  1  one-cycle split-busy reject pulse.

Behaviour:
- Clock and reset: single clock CLK. RSTN is asynchronous and active-low. In reset, all outputs are 0, the FSM is in IDLE, and the counters and shift registers are cleared.
- Reset mid-operation: RSTN low in any state forces the outputs low immediately (asynchronously) and returns the FSM to IDLE. No pulse is emitted.
- All outputs are registered.
- FSM states: IDLE, ID, WAIT_RDY, ADDR, [PAR], DONE.
- IDLE:
  - All bus outputs 0.
  - On M_REQ=1 at edge k with M_SLAVE_ID==SPLIT_ID and B_SBSY=1: reject. M_RETRY=1 during cycle k+1, FSM stays in IDLE, no bus activity.
  - Otherwise on M_REQ=1: latch id and address, go to ID. M_BUSY goes high from k+1.
- ID (SLAVE_W cycles):
  - B_UTIL=1, A_ADD=1.
  - B_BUS_OUT carries the id bits, MSB first. The first bit appears in cycle k+1.
- WAIT_RDY:
  - B_UTIL=1, A_ADD=0, B_BUS_OUT=0.
  - The wait counter starts at 0 and is incremented each cycle.
  - S_READY sampled 1 moves the FSM to ADDR on the next edge. The minimum is one WAIT_RDY cycle.
  - If the counter reaches TIMEOUT-1 without S_READY, the FSM goes to IDLE with M_ERR=1 for one cycle. B_UTIL drops in that same cycle.
  - S_READY and timeout in the same cycle: ready wins.
- ADDR (ADDR_W cycles):
  - B_UTIL=1, A_ADD=0.
  - B_BUS_OUT carries the address, MSB first, from a left-shift register with a bit counter.
- DONE (1 cycle): B_UTIL=0, M_DONE=1, M_BUSY=0. The FSM then returns to IDLE.
- A new M_REQ is accepted in the cycle after DONE, at the earliest.
- M_REQ while busy is ignored, not queued. The latched id and address are unaffected by input changes during a transfer.
- B_SBSY is sampled only at accept. A change during a transfer has no effect.
- Latency, request edge to M_DONE high:
  - SLAVE_W + W + ADDR_W + 1 cycles, where W is the number of WAIT_RDY cycles (≥1).
  - Plus 1 with the parity option.

Optional Feature:
- Macro ADDR_PARITY_EN.
- Defined: state PAR follows ADDR for one cycle, with B_UTIL=1, A_ADD=0 and B_BUS_OUT equal to the even parity (XOR) of the latched id and address bits. Latency grows by 1.
- Undefined: no PAR state; ADDR goes directly to DONE.

Test Plan:
- Split slave, no busy: B_SBSY=0, M_SLAVE_ID=10, M_ADDR=12'hA5C, S_READY high on the first wait cycle.
  -> A_ADD=1 for 2 cycles with bits 1,0, then 1 wait cycle, then 101001011100 with A_ADD=0.
  -> M_DONE at cycle 16 after request; B_UTIL high cycles 1-15.
- Split slave busy: M_SLAVE_ID=10, B_SBSY=1.
  -> M_RETRY pulse next cycle; B_UTIL, A_ADD and M_BUSY stay 0.
- 4K non-split while split busy: M_SLAVE_ID=01, B_SBSY=1, M_ADDR=12'h001, S_READY after 3 wait cycles.
  -> Id bits 0,1; 3 wait cycles; address ends in a single 1; M_DONE at cycle 18.
- Timeout: M_SLAVE_ID=00, S_READY held 0.
  -> Exactly 8 WAIT_RDY cycles, then M_ERR pulse with B_UTIL=0; no address bits sent.
- Reset mid-ADDR: RSTN low during the 5th address bit.
  -> All outputs 0 immediately. After release, IDLE; a new request to 2K slave completes normally.
- ADDR_PARITY_EN build: id 11, address 12'hFFF (14 ones).
  -> Parity bit 0 after the last address bit; M_DONE one cycle later than the non-parity build.

Source files
------------

// File: rtl/bus_address_transmitter_if.sv
// Master-core handshake and serial-bus lines of the bus address transmitter.
// The master modport is the transmitter's view; slave is the environment's.
interface bus_address_transmitter_if #(
    parameter int SLAVE_W = 2,
    parameter int ADDR_W  = 12
);
    logic               M_REQ;
    logic [SLAVE_W-1:0] M_SLAVE_ID;
    logic [ADDR_W-1:0]  M_ADDR;
    logic               B_SBSY;
    logic               S_READY;
    logic               B_UTIL;
    logic               A_ADD;
    logic               B_BUS_OUT;
    logic               M_BUSY;
    logic               M_DONE;
    logic               M_ERR;
    logic               M_RETRY;

    modport master (
        input  M_REQ, M_SLAVE_ID, M_ADDR, B_SBSY, S_READY,
        output B_UTIL, A_ADD, B_BUS_OUT, M_BUSY, M_DONE, M_ERR, M_RETRY
    );

    modport slave (
        output M_REQ, M_SLAVE_ID, M_ADDR, B_SBSY, S_READY,
        input  B_UTIL, A_ADD, B_BUS_OUT, M_BUSY, M_DONE, M_ERR, M_RETRY
    );
endinterface

// File: rtl/bus_address_transmitter.sv
// Serialises slave id then memory address onto B_UTIL/A_ADD/B_BUS_OUT.
// Optional macro ADDR_PARITY_EN appends one even-parity bit after the address.
module bus_address_transmitter #(
    parameter int                 SLAVE_W  = 2,
    parameter int                 ADDR_W   = 12,
    parameter logic [SLAVE_W-1:0] SPLIT_ID = 2'b10,
    parameter int                 TIMEOUT  = 8
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    bus_address_transmitter_if.master bus
);

    localparam int CNT_MAX = (ADDR_W > SLAVE_W) ? ADDR_W : SLAVE_W;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int WAIT_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  ID_LAST   = CNT_W'(SLAVE_W - 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ID,
        S_WAIT_RDY,
        S_ADDR,
`ifdef ADDR_PARITY_EN
        S_PAR,
`endif
        S_DONE
    } state_t;

    state_t             state_q,    state_d;
    logic [SLAVE_W-1:0] id_sh_q,    id_sh_d;
    logic [ADDR_W-1:0]  addr_sh_q,  addr_sh_d;
    logic [CNT_W-1:0]   bit_cnt_q,  bit_cnt_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic               util_q,     util_d;
    logic               aadd_q,     aadd_d;
    logic               bit_q,      bit_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic               err_q,      err_d;
    logic               retry_q,    retry_d;
`ifdef ADDR_PARITY_EN
    logic               par_q,      par_d;
`endif

    logic [SLAVE_W-1:0] id_shl;
    logic [ADDR_W-1:0]  addr_shl;
    logic               split_reject;

    assign id_shl       = id_sh_q << 1;
    assign addr_shl     = addr_sh_q << 1;
    assign split_reject = (bus.M_SLAVE_ID == SPLIT_ID) && bus.B_SBSY;

    // Next-state logic computes the outputs for the cycle after the edge,
    // so every bus line comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        id_sh_d    = id_sh_q;
        addr_sh_d  = addr_sh_q;
        bit_cnt_d  = bit_cnt_q;
        wait_cnt_d = wait_cnt_q;
        util_d     = 1'b0;
        aadd_d     = 1'b0;
        bit_d      = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        retry_d    = 1'b0;
`ifdef ADDR_PARITY_EN
        par_d      = par_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (bus.M_REQ) begin
                    if (split_reject) begin
                        retry_d = 1'b1;
                    end else begin
                        state_d   = S_ID;
                        id_sh_d   = bus.M_SLAVE_ID;
                        addr_sh_d = bus.M_ADDR;
                        bit_cnt_d = '0;
`ifdef ADDR_PARITY_EN
                        par_d     = ^{bus.M_SLAVE_ID, bus.M_ADDR};
`endif
                        util_d    = 1'b1;
                        aadd_d    = 1'b1;
                        bit_d     = bus.M_SLAVE_ID[SLAVE_W-1];
                        busy_d    = 1'b1;
                    end
                end
            end

            S_ID: begin
                util_d = 1'b1;
                busy_d = 1'b1;
                if (bit_cnt_q == ID_LAST) begin
                    state_d    = S_WAIT_RDY;
                    wait_cnt_d = '0;
                end else begin
                    aadd_d    = 1'b1;
                    id_sh_d   = id_shl;
                    bit_d     = id_shl[SLAVE_W-1];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

            // Ready is checked before the timeout so a late acknowledge still wins.
            S_WAIT_RDY: begin
                if (bus.S_READY) begin
                    state_d   = S_ADDR;
                    bit_cnt_d = '0;
                    util_d    = 1'b1;
                    busy_d    = 1'b1;
                    bit_d     = addr_sh_q[ADDR_W-1];
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    util_d     = 1'b1;
                    busy_d     = 1'b1;
                end
            end

            S_ADDR: begin
                if (bit_cnt_q == ADDR_LAST) begin
`ifdef ADDR_PARITY_EN
                    state_d = S_PAR;
                    util_d  = 1'b1;
                    busy_d  = 1'b1;
                    bit_d   = par_q;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
`endif
                end else begin
                    util_d    = 1'b1;
                    busy_d    = 1'b1;
                    addr_sh_d = addr_shl;
                    bit_d     = addr_shl[ADDR_W-1];
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end

`ifdef ADDR_PARITY_EN
            S_PAR: begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            id_sh_q    <= '0;
            addr_sh_q  <= '0;
            bit_cnt_q  <= '0;
            wait_cnt_q <= '0;
            util_q     <= 1'b0;
            aadd_q     <= 1'b0;
            bit_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            retry_q    <= 1'b0;
`ifdef ADDR_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            id_sh_q    <= id_sh_d;
            addr_sh_q  <= addr_sh_d;
            bit_cnt_q  <= bit_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            util_q     <= util_d;
            aadd_q     <= aadd_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            retry_q    <= retry_d;
`ifdef ADDR_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign bus.B_UTIL    = util_q;
    assign bus.A_ADD     = aadd_q;
    assign bus.B_BUS_OUT = bit_q;
    assign bus.M_BUSY    = busy_q;
    assign bus.M_DONE    = done_q;
    assign bus.M_ERR     = err_q;
    assign bus.M_RETRY   = retry_q;

endmodule

// File: tb/tb_bus_address_transmitter.sv
// Bench for bus_address_transmitter: directed and random requests compared
// cycle by cycle against an expected-waveform list built from the protocol rules.
module tb_bus_address_transmitter;

    localparam int                 SLAVE_W  = 2;
    localparam int                 ADDR_W   = 12;
    localparam int                 TIMEOUT  = 8;
    localparam logic [SLAVE_W-1:0] SPLIT_ID = 2'b10;
`ifdef ADDR_PARITY_EN
    localparam int                 PAR_CYC  = 1;
`else
    localparam int                 PAR_CYC  = 0;
`endif

    logic       CLK;
    logic       RSTN;
    int         n_chk;
    int         n_fail;
    int         xfer_no;
    logic [6:0] exp_q[$];

    bus_address_transmitter_if #(.SLAVE_W(SLAVE_W), .ADDR_W(ADDR_W)) bus_if ();

    bus_address_transmitter #(
        .SLAVE_W (SLAVE_W),
        .ADDR_W  (ADDR_W),
        .SPLIT_ID(SPLIT_ID),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .CLK (CLK),
        .RSTN(RSTN),
        .bus (bus_if)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required finish");
        $fatal(1, "watchdog");
    end

    // Output vector order: {B_UTIL, A_ADD, B_BUS_OUT, M_BUSY, M_DONE, M_ERR, M_RETRY}
    function automatic logic [6:0] obs();
        return {bus_if.B_UTIL, bus_if.A_ADD, bus_if.B_BUS_OUT, bus_if.M_BUSY,
                bus_if.M_DONE, bus_if.M_ERR, bus_if.M_RETRY};
    endfunction

    function automatic logic [6:0] ev(input logic u, input logic a, input logic b,
                                      input logic bsy, input logic d, input logic e,
                                      input logic r);
        return {u, a, b, bsy, d, e, r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // w = wait cycles until S_READY (w > TIMEOUT means never ready);
    // b2b holds M_REQ in the DONE cycle; rst_at asserts reset in that cycle.
    task automatic run_xfer(input logic [SLAVE_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic sbsy, input int w, input bit b2b, input int rst_at);
        bit         reject;
        bit         tmo;
        bit         aborted;
        int         nwait;
        int         n;
        int         done_cyc;
        logic [6:0] o;

        xfer_no++;
        reject = (id == SPLIT_ID) && sbsy;
        tmo    = !reject && (w > TIMEOUT);
        nwait  = tmo ? TIMEOUT : w;

        exp_q.delete();
        if (reject) begin
            exp_q.push_back(ev(0, 0, 0, 0, 0, 0, 1));
        end else begin
            for (int i = SLAVE_W - 1; i >= 0; i--) exp_q.push_back(ev(1, 1, id[i], 1, 0, 0, 0));
            for (int i = 0; i < nwait; i++) exp_q.push_back(ev(1, 0, 0, 1, 0, 0, 0));
            if (tmo) begin
                exp_q.push_back(ev(0, 0, 0, 0, 0, 1, 0));
            end else begin
                for (int i = ADDR_W - 1; i >= 0; i--) exp_q.push_back(ev(1, 0, addr[i], 1, 0, 0, 0));
`ifdef ADDR_PARITY_EN
                exp_q.push_back(ev(1, 0, ^{id, addr}, 1, 0, 0, 0));
`endif
                exp_q.push_back(ev(0, 0, 0, 0, 1, 0, 0));
            end
        end
        n = exp_q.size();

        @(negedge CLK);
        chk($sformatf("x%0d_idle_before", xfer_no), obs(), 7'd0);
        bus_if.M_REQ      = 1'b1;
        bus_if.M_SLAVE_ID = id;
        bus_if.M_ADDR     = addr;
        bus_if.B_SBSY     = sbsy;
        bus_if.S_READY    = 1'b0;

        done_cyc = 0;
        aborted  = 1'b0;
        for (int c = 1; c <= n; c++) begin
            @(negedge CLK);
            o = obs();
            chk($sformatf("x%0d_cyc%0d", xfer_no, c), o, exp_q[c-1]);
            if (o[2]) done_cyc = c;
            if (c == rst_at) begin
                RSTN = 1'b0;
                #1;
                chk($sformatf("x%0d_async_reset", xfer_no), obs(), 7'd0);
                bus_if.M_REQ   = 1'b0;
                bus_if.S_READY = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (c == n) begin
                bus_if.M_REQ   = b2b && !tmo && !reject;
                bus_if.S_READY = 1'b0;
            end else begin
                // Noise on inputs the transmitter must ignore mid-transfer.
                bus_if.M_REQ      = 1'($urandom_range(0, 1));
                bus_if.M_SLAVE_ID = SLAVE_W'($urandom);
                bus_if.M_ADDR     = ADDR_W'($urandom);
                bus_if.B_SBSY     = 1'($urandom_range(0, 1));
                if (c > SLAVE_W && c <= SLAVE_W + nwait)
                    bus_if.S_READY = (c == SLAVE_W + w);
                else
                    bus_if.S_READY = 1'($urandom_range(0, 1));
            end
        end

        if (!reject && !tmo && !aborted)
            chk($sformatf("x%0d_latency", xfer_no), done_cyc, SLAVE_W + w + ADDR_W + 1 + PAR_CYC);
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        xfer_no = 0;
        RSTN    = 1'b0;
        bus_if.M_REQ      = 1'b1;
        bus_if.M_SLAVE_ID = 2'b01;
        bus_if.M_ADDR     = 12'hFFF;
        bus_if.B_SBSY     = 1'b0;
        bus_if.S_READY    = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk($sformatf("reset_state%0d", i), obs(), 7'd0);
        end
        bus_if.M_REQ   = 1'b0;
        bus_if.S_READY = 1'b0;
        RSTN = 1'b1;

        // Split slave free, ready on first wait cycle: done at cycle 16 (+parity).
        run_xfer(2'b10, 12'hA5C, 1'b0, 1, 1'b0, 0);
        // Split slave busy: retry pulse only.
        run_xfer(2'b10, 12'h3C3, 1'b1, 1, 1'b0, 0);
        // Non-split slave while split busy, 3 wait cycles: done at cycle 18.
        run_xfer(2'b01, 12'h001, 1'b1, 3, 1'b0, 0);
        // Never ready: 8 wait cycles then error.
        run_xfer(2'b00, 12'h7E1, 1'b0, 100, 1'b0, 0);
        // Ready arrives on the last allowed wait cycle.
        run_xfer(2'b01, 12'h9A6, 1'b0, TIMEOUT, 1'b0, 0);
        // Reset during the 5th address bit.
        run_xfer(2'b01, 12'hABC, 1'b0, 2, 1'b0, SLAVE_W + 2 + 5);
        @(negedge CLK);
        chk("held_reset", obs(), 7'd0);
        RSTN = 1'b1;
        run_xfer(2'b00, 12'h123, 1'b0, 1, 1'b0, 0);
        // All-ones id and address: parity bit 0.
        run_xfer(2'b11, 12'hFFF, 1'b0, 1, 1'b0, 0);
        // Request held through DONE is ignored there, then accepted.
        run_xfer(2'b00, 12'h555, 1'b0, 2, 1'b1, 0);
        run_xfer(2'b11, 12'h0F0, 1'b0, 4, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            run_xfer(SLAVE_W'($urandom), ADDR_W'($urandom), 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, TIMEOUT + 2)), bit'($urandom_range(0, 1)), 0);
        end

        @(negedge CLK);
        chk("idle_final", obs(), 7'd0);
        bus_if.M_REQ = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
